l2_miss_read_responder: RTL and testbench

- Behavioural L2-side responder for the data-cache miss-read channel in the core_tile simulation environment.
- Sits directly downstream of the tile's miss-read request port (`mem_req_miss_read_*`) and feeds the response port (`mem_resp_miss_read_*`).
- Queues line-refill requests, applies a programmable access latency, and reads beats from a synchronous backing-memory port.
- Returns multi-beat responses tagged with the request id and a last flag, honouring response backpressure.

---
 rtl/l2_miss_read_responder_if.sv | 53 +++++
 rtl/l2_miss_read_responder.sv | 176 +++++++++++++++++
 tb/tb_l2_miss_read_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l2_miss_read_responder_if.sv
// ---------------------------------------------------------------------------
// l2_miss_read_responder_if
// Bundles the three channels seen by the L2 miss-read responder:
//   request  : req_valid_i / req_ready_o / req_addr_i / req_len_i /
//              req_size_i / req_id_i          (tile -> responder)
//   memory   : mem_rd_en_o / mem_rd_addr_o / mem_rd_data_i
//              (synchronous backing store, data one cycle after the strobe)
//   response : resp_valid_o / resp_ready_i / resp_data_o / resp_id_o /
//              resp_last_o / resp_error_o     (responder -> tile)
// Signal suffixes are from the responder's point of view.
// slave modport  : the responder itself.
// master modport : the environment driving requests, memory data and ready.
// ---------------------------------------------------------------------------
interface l2_miss_read_responder_if #(
  parameter int ADDR_W = 40,
  parameter int DATA_W = 128,
  parameter int ID_W   = 4
);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int BIDX_W = ADDR_W - OFF_W;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [7:0]        req_len_i;
  logic [2:0]        req_size_i;
  logic [ID_W-1:0]   req_id_i;

  logic              mem_rd_en_o;
  logic [BIDX_W-1:0] mem_rd_addr_o;
  logic [DATA_W-1:0] mem_rd_data_i;

  logic              resp_valid_o;
  logic              resp_ready_i;
  logic [DATA_W-1:0] resp_data_o;
  logic [ID_W-1:0]   resp_id_o;
  logic              resp_last_o;
  logic              resp_error_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_len_i, req_size_i, req_id_i,
    input  mem_rd_data_i, resp_ready_i,
    output req_ready_o, mem_rd_en_o, mem_rd_addr_o,
    output resp_valid_o, resp_data_o, resp_id_o, resp_last_o, resp_error_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_len_i, req_size_i, req_id_i,
    output mem_rd_data_i, resp_ready_i,
    input  req_ready_o, mem_rd_en_o, mem_rd_addr_o,
    input  resp_valid_o, resp_data_o, resp_id_o, resp_last_o, resp_error_o
  );
endinterface

// File: rtl/l2_miss_read_responder.sv
// ---------------------------------------------------------------------------
// l2_miss_read_responder
// Behavioural L2 responder for the data-cache miss-read channel. Requests are
// queued in a small FIFO; each one is served by an IDLE/WAIT/READ/RESP FSM
// that waits LATENCY cycles, then reads one beat per READ from a synchronous
// backing memory and presents it on the response channel until accepted.
// Ports:
//   clk_i   : clock
//   rstn_i  : synchronous active-low reset (flushes FIFO, FSM to IDLE)
//   bus     : l2_miss_read_responder_if.slave (request, memory and response
//             channels)
// ---------------------------------------------------------------------------
module l2_miss_read_responder #(
  parameter int ADDR_W     = 40,
  parameter int DATA_W     = 128,
  parameter int ID_W       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int LATENCY    = 8
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  l2_miss_read_responder_if.slave  bus
);
  localparam int         OFF_W  = $clog2(DATA_W / 8);
  localparam int         BIDX_W = ADDR_W - OFF_W;
  localparam int         PTR_W  = $clog2(FIFO_DEPTH);
  localparam int         ENT_W  = 1 + ID_W + 8 + BIDX_W;
  localparam logic [7:0] LAT_C  = 8'(LATENCY);
  localparam logic [2:0] SIZE_C = 3'(OFF_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READ, S_RESP} state_e;

  // Request FIFO: one extra pointer bit distinguishes full from empty.
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] push_ent, head_ent;

  // FSM and per-request context.
  state_e            state_q, state_d;
  logic [BIDX_W-1:0] base_q, base_d;
  logic [7:0]        len_q, len_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              err_q, err_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        wait_q, wait_d;
  // fresh_q marks the first RESP cycle of a beat, when the memory data is
  // still on mem_rd_data_i and has not yet been captured into data_q.
  logic              fresh_q, fresh_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              in_resp, last;

  // Byte-offset bits of the request address do not select anything.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.req_addr_i[OFF_W-1:0];

  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Gating with rstn_i keeps ready low for the whole reset cycle.
  assign bus.req_ready_o = rstn_i && !full;
  assign push            = bus.req_valid_i && bus.req_ready_o;
  assign push_ent        = {(bus.req_size_i != SIZE_C), bus.req_id_i,
                            bus.req_len_i, bus.req_addr_i[ADDR_W-1:OFF_W]};
  assign head_ent        = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr_q[PTR_W-1:0]] <= push_ent;
    end
  end

  assign in_resp = (state_q == S_RESP);
  assign last    = (beat_q == len_q);

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    len_d    = len_q;
    id_d     = id_q;
    err_d    = err_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
    fresh_d  = 1'b0;
    data_d   = data_q;
    pop      = 1'b0;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (fresh_q) begin
      data_d = bus.mem_rd_data_i;
    end

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop                         = 1'b1;
          {err_d, id_d, len_d, base_d} = head_ent;
          beat_d                      = 8'd0;
          wait_d                      = LAT_C;
          state_d                     = (LAT_C == 8'd0) ? S_READ : S_WAIT;
        end
      end
      S_WAIT: begin
        wait_d = wait_q - 8'd1;
        if (wait_q == 8'd1) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        fresh_d = 1'b1;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready_i) begin
          if (last) begin
            state_d = S_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
            state_d = S_READ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      base_q   <= '0;
      len_q    <= '0;
      id_q     <= '0;
      err_q    <= 1'b0;
      beat_q   <= '0;
      wait_q   <= '0;
      fresh_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      id_q     <= id_d;
      err_q    <= err_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
      fresh_q  <= fresh_d;
    end
  end

  // Beat data is only ever observed through the gated resp_data_o.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

  assign bus.mem_rd_en_o   = (state_q == S_READ) && !err_q;
  // Beat index wraps silently at the top of the address space.
  assign bus.mem_rd_addr_o = base_q + BIDX_W'(beat_q);
  assign bus.resp_valid_o  = in_resp;
  assign bus.resp_last_o   = in_resp && last;
  assign bus.resp_error_o  = in_resp && err_q;
  assign bus.resp_id_o     = id_q;
  assign bus.resp_data_o   = (!in_resp || err_q) ? '0 :
                             (fresh_q ? bus.mem_rd_data_i : data_q);
endmodule

// File: tb/tb_l2_miss_read_responder.sv
module tb_l2_miss_read_responder;
  logic clk;
  logic rstn;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   id;
    logic         last;
    logic         err;
    int           cyc;
  } beat_t;

  typedef struct {
    logic [35:0] addr;
    int          cyc;
  } rd_t;

  typedef struct {
    logic [3:0]  id;
    logic [39:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    bit          rnd;
    bit          timed;
    logic        exp_err;
  } vec_t;

  beat_t q8[$];
  beat_t q0[$];
  rd_t   rd8[$];
  rd_t   rd0[$];

  l2_miss_read_responder_if #(.ADDR_W(40), .DATA_W(128), .ID_W(4)) if8();
  l2_miss_read_responder_if #(.ADDR_W(40), .DATA_W(128), .ID_W(4)) if0();

  l2_miss_read_responder #(.ADDR_W(40), .DATA_W(128), .ID_W(4),
                           .FIFO_DEPTH(4), .LATENCY(8))
    dut8 (.clk_i(clk), .rstn_i(rstn), .bus(if8));

  l2_miss_read_responder #(.ADDR_W(40), .DATA_W(128), .ID_W(4),
                           .FIFO_DEPTH(4), .LATENCY(0))
    dut0 (.clk_i(clk), .rstn_i(rstn), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] memword(input logic [35:0] idx);
    return {idx[31:0] ^ 32'hDEAD_0000, ~idx[31:0], idx[31:0] + 32'h1111_1111,
            {28'hC0DE000, idx[35:32]}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Synchronous backing memories; garbage whenever no read was strobed.
  always @(posedge clk) begin
    if (if8.mem_rd_en_o) if8.mem_rd_data_i <= memword(if8.mem_rd_addr_o);
    else                 if8.mem_rd_data_i <= {$urandom, $urandom, $urandom, $urandom};
    if (if0.mem_rd_en_o) if0.mem_rd_data_i <= memword(if0.mem_rd_addr_o);
    else                 if0.mem_rd_data_i <= {$urandom, $urandom, $urandom, $urandom};
  end

  // Monitors: record handshakes and memory reads, check hold-while-stalled.
  logic         stall_prev = 1'b0;
  logic [127:0] p_data;
  logic [3:0]   p_id;
  logic         p_last, p_err;

  always @(negedge clk) begin
    if (rstn) begin
      if (if8.resp_valid_o && if8.resp_ready_i)
        q8.push_back('{if8.resp_data_o, if8.resp_id_o, if8.resp_last_o, if8.resp_error_o, cyc});
      if (if8.mem_rd_en_o) rd8.push_back('{if8.mem_rd_addr_o, cyc});
      if (if0.resp_valid_o && if0.resp_ready_i)
        q0.push_back('{if0.resp_data_o, if0.resp_id_o, if0.resp_last_o, if0.resp_error_o, cyc});
      if (if0.mem_rd_en_o) rd0.push_back('{if0.mem_rd_addr_o, cyc});
      if (stall_prev) begin
        chk("hold_valid", if8.resp_valid_o, 1'b1);
        chk("hold_data",  if8.resp_data_o,  p_data);
        chk("hold_id",    if8.resp_id_o,    p_id);
        chk("hold_last",  if8.resp_last_o,  p_last);
        chk("hold_err",   if8.resp_error_o, p_err);
      end
      stall_prev <= if8.resp_valid_o && !if8.resp_ready_i;
    end else begin
      stall_prev <= 1'b0;
    end
    p_data <= if8.resp_data_o;
    p_id   <= if8.resp_id_o;
    p_last <= if8.resp_last_o;
    p_err  <= if8.resp_error_o;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push8(input logic [3:0] id, input logic [39:0] addr, input logic [7:0] len,
                       input logic [2:0] size, output int pcyc, output bit ok);
    if8.req_valid_i = 1'b1;
    if8.req_id_i    = id;
    if8.req_addr_i  = addr;
    if8.req_len_i   = len;
    if8.req_size_i  = size;
    ok   = 1'b0;
    pcyc = 0;
    for (int w = 0; w < 60 && !ok; w++) begin
      @(negedge clk);
      if (if8.req_ready_o) begin
        ok   = 1'b1;
        pcyc = cyc;
      end
      @(posedge clk);
      #1;
    end
    if8.req_valid_i = 1'b0;
  endtask

  task automatic wait_beats8(input int n, input int budget);
    for (int w = 0; w < budget && q8.size() < n; w++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t        vt[5];
  int          p;
  bit          ok;
  logic [35:0] base;
  int          rdy_hi;
  int          rds_at_rst;
  bit          found;
  logic [127:0] snap_data;
  logic [3:0]   snap_id;
  logic         snap_valid;

  initial begin
    vt[0] = '{4'd3,  40'h00_0000_1000, 8'd3, 3'd4, 1'b0, 1'b1, 1'b0};
    vt[1] = '{4'd10, 40'h00_0000_0000, 8'd7, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[2] = '{4'd5,  40'h00_0000_2000, 8'd1, 3'd3, 1'b0, 1'b0, 1'b1};
    vt[3] = '{4'd15, 40'h00_0000_3018, 8'd0, 3'd4, 1'b1, 1'b0, 1'b0};
    vt[4] = '{4'd7,  40'h00_0000_4000, 8'd2, 3'd5, 1'b1, 1'b0, 1'b1};

    rstn = 1'b0;
    if8.req_valid_i = 1'b0; if8.req_addr_i = '0; if8.req_len_i = '0;
    if8.req_size_i = '0; if8.req_id_i = '0; if8.resp_ready_i = 1'b0;
    if0.req_valid_i = 1'b0; if0.req_addr_i = '0; if0.req_len_i = '0;
    if0.req_size_i = '0; if0.req_id_i = '0; if0.resp_ready_i = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready",  if8.req_ready_o,   1'b0);
    chk("rst_mem_rd_en",  if8.mem_rd_en_o,   1'b0);
    chk("rst_mem_addr",   if8.mem_rd_addr_o, 36'h0);
    chk("rst_resp_valid", if8.resp_valid_o,  1'b0);
    chk("rst_resp_last",  if8.resp_last_o,   1'b0);
    chk("rst_resp_err",   if8.resp_error_o,  1'b0);
    chk("rst_resp_data",  if8.resp_data_o,   128'h0);
    chk("rst_resp_id",    if8.resp_id_o,     4'h0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    if8.resp_ready_i = 1'b1;
    if0.resp_ready_i = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", if8.req_ready_o, 1'b1);
    @(posedge clk);
    #1;

    // Table-driven single requests
    for (int i = 0; i < 5; i++) begin
      q8.delete();
      rd8.delete();
      if8.resp_ready_i = 1'b1;
      base = vt[i].addr[39:4];
      push8(vt[i].id, vt[i].addr, vt[i].len, vt[i].size, p, ok);
      chk($sformatf("v%0d_push", i), ok, 1'b1);
      for (int w = 0; w < 400 && q8.size() < int'(vt[i].len) + 1; w++) begin
        @(posedge clk);
        #1;
        if (vt[i].rnd) if8.resp_ready_i = 1'($urandom_range(0, 1));
      end
      if8.resp_ready_i = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      chk($sformatf("v%0d_beats", i), q8.size(), int'(vt[i].len) + 1);
      for (int k = 0; k < q8.size(); k++) begin
        chk($sformatf("v%0d_b%0d_id", i, k),   q8[k].id,   vt[i].id);
        chk($sformatf("v%0d_b%0d_last", i, k), q8[k].last, (k == int'(vt[i].len)));
        chk($sformatf("v%0d_b%0d_err", i, k),  q8[k].err,  vt[i].exp_err);
        chk($sformatf("v%0d_b%0d_data", i, k), q8[k].data,
            vt[i].exp_err ? 128'h0 : memword(base + 36'(k)));
        if (vt[i].timed)
          chk($sformatf("v%0d_b%0d_cycle", i, k), q8[k].cyc, p + 11 + 2 * k);
      end
      chk($sformatf("v%0d_rd_count", i), rd8.size(),
          vt[i].exp_err ? 0 : int'(vt[i].len) + 1);
      for (int k = 0; k < rd8.size(); k++)
        chk($sformatf("v%0d_rd%0d_addr", i, k), rd8[k].addr, base + 36'(k));
    end

    // Backpressure: fill the FIFO behind a stalled request, then drain
    q8.delete();
    rd8.delete();
    if8.resp_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push8(4'(i), 40'h1_0000 + 40'(i) * 40'h100, 8'd0, 3'd4, p, ok);
      chk($sformatf("bp_push%0d", i), ok, 1'b1);
    end
    @(negedge clk);
    chk("bp_full_ready", if8.req_ready_o, 1'b0);
    @(posedge clk);
    #1;
    if8.req_valid_i = 1'b1;
    if8.req_id_i    = 4'd6;
    if8.req_addr_i  = 40'h1_0600;
    if8.req_len_i   = 8'd0;
    if8.req_size_i  = 3'd4;
    rdy_hi = 0;
    snap_valid = 1'b0;
    snap_data = '0;
    snap_id = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if8.req_ready_o) rdy_hi++;
      if (i == 15) begin
        snap_valid = if8.resp_valid_o;
        snap_data  = if8.resp_data_o;
        snap_id    = if8.resp_id_o;
      end
    end
    chk("bp_stalled_ready_cycles", rdy_hi, 0);
    chk("bp_snap_valid", snap_valid, 1'b1);
    chk("bp_snap_data", snap_data, memword(36'h1010));
    chk("bp_hold_valid_end", if8.resp_valid_o, 1'b1);
    chk("bp_hold_data_end", if8.resp_data_o, snap_data);
    chk("bp_hold_id_end", if8.resp_id_o, snap_id);
    @(posedge clk);
    #1;
    if8.resp_ready_i = 1'b1;
    push8(4'd6, 40'h1_0600, 8'd0, 3'd4, p, ok);
    chk("bp_push6", ok, 1'b1);
    wait_beats8(6, 400);
    chk("bp_beats", q8.size(), 6);
    for (int k = 0; k < q8.size(); k++) begin
      chk($sformatf("bp_b%0d_id", k), q8[k].id, 4'(k + 1));
      chk($sformatf("bp_b%0d_data", k), q8[k].data, memword(36'h1000 + 36'((k + 1) * 16)));
    end

    // LATENCY=0: beat-index wrap at the top of the address space
    q0.delete();
    rd0.delete();
    if0.req_valid_i = 1'b1;
    if0.req_id_i    = 4'd9;
    if0.req_addr_i  = 40'hFF_FFFF_FFF0;
    if0.req_len_i   = 8'd1;
    if0.req_size_i  = 3'd4;
    ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      @(negedge clk);
      if (if0.req_ready_o) begin
        ok = 1'b1;
        p  = cyc;
      end
      @(posedge clk);
      #1;
    end
    if0.req_valid_i = 1'b0;
    chk("l0_push", ok, 1'b1);
    for (int w = 0; w < 50 && q0.size() < 2; w++) begin
      @(posedge clk);
      #1;
    end
    repeat (5) @(posedge clk);
    #1;
    chk("l0_beats", q0.size(), 2);
    chk("l0_rd_count", rd0.size(), 2);
    if (rd0.size() == 2) begin
      chk("l0_rd0_addr", rd0[0].addr, 36'hF_FFFF_FFFF);
      chk("l0_rd1_addr", rd0[1].addr, 36'h0);
    end
    if (q0.size() == 2) begin
      chk("l0_b0_cycle", q0[0].cyc, p + 3);
      chk("l0_b1_cycle", q0[1].cyc, p + 5);
      chk("l0_b0_data", q0[0].data, memword(36'hF_FFFF_FFFF));
      chk("l0_b1_data", q0[1].data, memword(36'h0));
      chk("l0_b0_last", q0[0].last, 1'b0);
      chk("l0_b1_last", q0[1].last, 1'b1);
      chk("l0_b1_id", q0[1].id, 4'd9);
    end

    // Reset during the second beat of a 4-beat burst with 2 queued
    q8.delete();
    rd8.delete();
    if8.resp_ready_i = 1'b1;
    push8(4'd2, 40'h5000, 8'd3, 3'd4, p, ok);
    chk("rst_pushA", ok, 1'b1);
    push8(4'd4, 40'h6000, 8'd3, 3'd4, p, ok);
    chk("rst_pushB", ok, 1'b1);
    push8(4'd6, 40'h7000, 8'd3, 3'd4, p, ok);
    chk("rst_pushC", ok, 1'b1);
    found = 1'b0;
    for (int w = 0; w < 100 && !found; w++) begin
      @(posedge clk);
      #1;
      if (q8.size() >= 1 && if8.resp_valid_o) found = 1'b1;
    end
    chk("rst_second_beat_seen", found, 1'b1);
    if8.resp_ready_i = 1'b0;
    rstn = 1'b0;
    @(posedge clk);
    #1;
    rstn = 1'b1;
    rds_at_rst = rd8.size();
    @(negedge clk);
    chk("rst_mid_valid", if8.resp_valid_o, 1'b0);
    chk("rst_mid_ready", if8.req_ready_o, 1'b1);
    if8.resp_ready_i = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    chk("rst_no_more_beats", q8.size(), 1);
    chk("rst_no_more_reads", rd8.size(), rds_at_rst);

    // Recovery after reset
    q8.delete();
    push8(4'd12, 40'h8000, 8'd0, 3'd4, p, ok);
    chk("rec_push", ok, 1'b1);
    wait_beats8(1, 100);
    repeat (4) @(posedge clk);
    #1;
    chk("rec_beats", q8.size(), 1);
    if (q8.size() == 1) begin
      chk("rec_id", q8[0].id, 4'd12);
      chk("rec_data", q8[0].data, memword(36'h800));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
